// File: rtl/input_block_loader_pkg.sv
// Shared types and helpers for the SRAM-to-systolic-array block loader.
package input_loader_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } ld_state_e;

    localparam int SLOTS = 2;

    // Select width for an n-way choice; a single choice still needs one bit.
    function automatic int sel_width(input int n);
        if (n > 1) begin
            sel_width = $clog2(n);
        end else begin
            sel_width = 1;
        end
    endfunction

    // Position of the chosen segment counted from the LS end; index 0 names the MS segment.
    function automatic int seg_index(input int sel, input int nseg);
        if (sel < nseg) begin
            seg_index = nseg - 1 - sel;
        end else begin
            seg_index = 0;
        end
    endfunction

endpackage

// File: rtl/input_block_loader_if.sv
// Handshake bundle between the SRAM read port, the loader and the MAC array feeder.
interface input_block_loader_if #(
    parameter int SRAM_W = 64,
    parameter int SEG_W  = 32,
    parameter int ROWS   = 4,
    parameter int TAG_W  = 4
);
    import input_loader_pkg::*;

    localparam int SEL_W = sel_width(SRAM_W / SEG_W);

    logic                    start;
    logic [SEL_W-1:0]        seg_sel;
    logic [TAG_W-1:0]        tag_in;
    logic                    sram_valid;
    logic [SRAM_W-1:0]       sram_data;
    logic                    load_ready;
    logic                    blk_valid;
    logic                    blk_ready;
    logic [ROWS*SEG_W-1:0]   blk_data;
    logic [TAG_W-1:0]        blk_tag;
    logic                    busy;

    modport master (
        output start, seg_sel, tag_in, sram_valid, sram_data, blk_ready,
        input  load_ready, blk_valid, blk_data, blk_tag, busy
    );

    modport slave (
        input  start, seg_sel, tag_in, sram_valid, sram_data, blk_ready,
        output load_ready, blk_valid, blk_data, blk_tag, busy
    );

endinterface

// File: rtl/input_block_loader_pingpong_block_buf.sv
// Two-slot block store: rows are written into the fill slot, committed blocks are read in order.
module pingpong_block_buf
    import input_loader_pkg::*;
#(
    parameter int SEG_W = 32,
    parameter int ROWS  = 4,
    parameter int TAG_W = 4,
    parameter int ROW_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_wr,
    input  logic [ROW_W-1:0]      row_idx,
    input  logic [SEG_W-1:0]      row_data,
    input  logic                  commit,
    input  logic [TAG_W-1:0]      commit_tag,
    input  logic                  pop_req,
    output logic                  full,
    output logic                  valid,
    output logic [ROWS*SEG_W-1:0] rd_data,
    output logic [TAG_W-1:0]      rd_tag
);

    logic [ROWS*SEG_W-1:0] slot_r [SLOTS];
    logic [TAG_W-1:0]      tag_r  [SLOTS];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            occ_r;
    logic                  pop_s;
    logic                  push_s;

    // Pops are qualified by occupancy so a ready with nothing stored is ignored.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (occ_r != 2'd0) begin
            pop_s = pop_req;
        end else begin
            pop_s = 1'b0;
        end
        if (occ_r != 2'd2) begin
            push_s = commit;
        end else begin
            push_s = 1'b0;
        end
    end

    // Slot storage: row 0 lands in the MS segment of the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_r[i] <= '0;
                tag_r[i]  <= '0;
            end
        end else begin
            if (row_wr) begin
                slot_r[wr_ptr_r][(ROWS - 1 - int'(row_idx)) * SEG_W +: SEG_W] <= row_data;
            end
            if (push_s) begin
                tag_r[wr_ptr_r] <= commit_tag;
            end
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous commit and pop leaves occ unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign full    = (occ_r == 2'd2);
    assign valid   = (occ_r != 2'd0);
    assign rd_data = slot_r[rd_ptr_r];
    assign rd_tag  = tag_r[rd_ptr_r];

endmodule

// File: rtl/input_block_loader.sv
// Slices one segment from each accepted SRAM word and packs ROWS of them into a block.
module input_block_loader
    import input_loader_pkg::*;
#(
    parameter int SRAM_W = 64,
    parameter int SEG_W  = 32,
    parameter int ROWS   = 4,
    parameter int TAG_W  = 4
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input_block_loader_if.slave  bus
);

    localparam int NSEG  = SRAM_W / SEG_W;
    localparam int SEL_W = sel_width(NSEG);
    localparam int ROW_W = sel_width(ROWS);

    ld_state_e         state_r;
    logic              busy_r;
    logic [ROW_W-1:0]  row_cnt_r;
    logic [SEL_W-1:0]  sel_r;
    logic [TAG_W-1:0]  tag_r;

    logic              full_s;
    logic              load_ready_s;
    logic              accept_s;
    logic              commit_s;
    logic [SEG_W-1:0]  seg_s;

    // Accept/commit qualification and segment extraction from the current SRAM word.
    always_comb begin
        load_ready_s = 1'b0;
        accept_s     = 1'b0;
        commit_s     = 1'b0;
        seg_s        = SEG_W'(bus.sram_data >> (SEG_W * seg_index(int'(sel_r), NSEG)));
        if (state_r == FILL) begin
            load_ready_s = ~full_s;
        end else begin
            load_ready_s = 1'b0;
        end
        accept_s = load_ready_s & bus.sram_valid;
        if (row_cnt_r == ROW_W'(ROWS - 1)) begin
            commit_s = accept_s;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Control FSM; a start always wins and restarts the fill, after any commit on the same edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            row_cnt_r <= '0;
            sel_r     <= '0;
            tag_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r   <= FILL;
                        busy_r    <= 1'b1;
                        row_cnt_r <= '0;
                        sel_r     <= bus.seg_sel;
                        tag_r     <= bus.tag_in;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                FILL: begin
                    if (bus.start) begin
                        state_r   <= FILL;
                        busy_r    <= 1'b1;
                        row_cnt_r <= '0;
                        sel_r     <= bus.seg_sel;
                        tag_r     <= bus.tag_in;
                    end else if (commit_s) begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                        row_cnt_r <= '0;
                    end else if (accept_s) begin
                        row_cnt_r <= row_cnt_r + ROW_W'(1);
                    end else begin
                        state_r <= FILL;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    row_cnt_r <= '0;
                end
            endcase
        end
    end

    pingpong_block_buf #(
        .SEG_W (SEG_W),
        .ROWS  (ROWS),
        .TAG_W (TAG_W),
        .ROW_W (ROW_W)
    ) u_buf (
        .clk        (CLK),
        .rst_n      (RSTN),
        .row_wr     (accept_s),
        .row_idx    (row_cnt_r),
        .row_data   (seg_s),
        .commit     (commit_s),
        .commit_tag (tag_r),
        .pop_req    (bus.blk_ready),
        .full       (full_s),
        .valid      (bus.blk_valid),
        .rd_data    (bus.blk_data),
        .rd_tag     (bus.blk_tag)
    );

    assign bus.load_ready = load_ready_s;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_input_block_loader.sv
// Directed and randomized bench for input_block_loader with a queue-based block model.
module tb_input_block_loader;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    input_block_loader_if #(.SRAM_W(64),  .SEG_W(32), .ROWS(4), .TAG_W(4)) a_if ();
    input_block_loader_if #(.SRAM_W(128), .SEG_W(16), .ROWS(8), .TAG_W(4)) b_if ();

    input_block_loader #(.SRAM_W(64), .SEG_W(32), .ROWS(4), .TAG_W(4)) dut_a (
        .CLK (CLK), .RSTN (RSTN), .bus (a_if)
    );
    input_block_loader #(.SRAM_W(128), .SEG_W(16), .ROWS(8), .TAG_W(4)) dut_b (
        .CLK (CLK), .RSTN (RSTN), .bus (b_if)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Model for dut_a: committed blocks {tag, data} in order, plus the rows of the block being filled.
    logic [131:0] exp_q [$];
    logic [31:0]  rows_q [$];
    bit           m_fill = 1'b0;
    bit           m_sel  = 1'b0;
    logic [3:0]   m_tag  = 4'd0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic check_vec(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare dut_a against the model, advance the model by this edge's inputs, then clock.
    task automatic tick();
        int occ0;
        logic [131:0] head;
        if (RSTN) begin
            occ0 = exp_q.size();
            check_bit("load_ready", a_if.load_ready, m_fill && (occ0 < 2));
            check_bit("blk_valid", a_if.blk_valid, occ0 != 0);
            check_bit("busy", a_if.busy, m_fill);
            if (occ0 != 0) begin
                head = exp_q[0];
                check_vec("blk_data", 132'(a_if.blk_data), 132'(head[127:0]));
                check_vec("blk_tag", 132'(a_if.blk_tag), 132'(head[131:128]));
                if (a_if.blk_ready) void'(exp_q.pop_front());
            end
            if (m_fill && (occ0 < 2) && a_if.sram_valid) begin
                rows_q.push_back(m_sel ? a_if.sram_data[31:0] : a_if.sram_data[63:32]);
                if (rows_q.size() == 4) begin
                    exp_q.push_back({m_tag, rows_q[0], rows_q[1], rows_q[2], rows_q[3]});
                    rows_q.delete();
                    m_fill = 1'b0;
                end
            end
            if (a_if.start) begin
                m_fill = 1'b1;
                rows_q.delete();
                m_sel = a_if.seg_sel;
                m_tag = a_if.tag_in;
            end
        end else begin
            exp_q.delete();
            rows_q.delete();
            m_fill = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic start_blk(input logic sel, input logic [3:0] tag);
        a_if.start   = 1'b1;
        a_if.seg_sel = sel;
        a_if.tag_in  = tag;
        tick();
        a_if.start = 1'b0;
    endtask

    // Feed words until the model says the block committed; random mode also randomizes valid/ready.
    task automatic fill(input bit rnd);
        for (int c = 0; c < 200 && m_fill; c++) begin
            a_if.sram_valid = rnd ? 1'($urandom) : 1'b1;
            a_if.sram_data  = {$urandom, $urandom};
            if (rnd) a_if.blk_ready = 1'($urandom);
            tick();
        end
        a_if.sram_valid = 1'b0;
        check_bit("fill_timeout", m_fill, 1'b0);
    endtask

    task automatic drain();
        a_if.blk_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        a_if.blk_ready = 1'b0;
        check_bit("drain_timeout", exp_q.size() == 0, 1'b1);
    endtask

    task automatic feed(input int n);
        a_if.sram_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            a_if.sram_data = {$urandom, $urandom};
            tick();
        end
        a_if.sram_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] bw;
        logic [127:0] bexp;
        a_if.start = 1'b0; a_if.seg_sel = 1'b0; a_if.tag_in = 4'd0;
        a_if.sram_valid = 1'b0; a_if.sram_data = 64'd0; a_if.blk_ready = 1'b0;
        b_if.start = 1'b0; b_if.seg_sel = 3'd0; b_if.tag_in = 4'd0;
        b_if.sram_valid = 1'b0; b_if.sram_data = 128'd0; b_if.blk_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check_bit("rst_load_ready", a_if.load_ready, 1'b0);
        check_bit("rst_blk_valid", a_if.blk_valid, 1'b0);
        check_bit("rst_busy", a_if.busy, 1'b0);
        check_vec("rst_blk_data", 132'(a_if.blk_data), 132'd0);
        check_vec("rst_blk_tag", 132'(a_if.blk_tag), 132'd0);
        check_bit("rst_b_valid", b_if.blk_valid, 1'b0);
        RSTN = 1'b1;
        tick();

        // 1: known words, select LS segment
        a_if.blk_ready = 1'b1;
        start_blk(1'b1, 4'd5);
        for (int k = 0; k < 4; k++) begin
            a_if.sram_valid = 1'b1;
            a_if.sram_data  = 64'h11111111_AAAA0000 | 64'(k);
            tick();
        end
        a_if.sram_valid = 1'b0;
        check_bit("t1_valid", a_if.blk_valid, 1'b1);
        check_vec("t1_data", 132'(a_if.blk_data), 132'(128'hAAAA0000_AAAA0001_AAAA0002_AAAA0003));
        check_vec("t1_tag", 132'(a_if.blk_tag), 132'(4'd5));
        tick();
        check_bit("t1_popped", a_if.blk_valid, 1'b0);

        // sram_valid in IDLE and blk_ready with nothing stored are ignored
        a_if.sram_valid = 1'b1;
        repeat (2) tick();
        a_if.sram_valid = 1'b0;
        a_if.blk_ready = 1'b0;

        // Random blocks with random valid/ready gaps
        for (int b = 0; b < 6; b++) begin
            start_blk(1'($urandom), 4'($urandom));
            fill(1'b1);
        end
        drain();

        // 2: three back-to-back blocks with the consumer stalled
        a_if.blk_ready = 1'b0;
        start_blk(1'b0, 4'd1);
        fill(1'b0);
        start_blk(1'b1, 4'd2);
        fill(1'b0);
        start_blk(1'b0, 4'd3);
        a_if.sram_valid = 1'b1;
        repeat (3) tick();
        check_bit("t2_stall", a_if.load_ready, 1'b0);
        check_bit("t2_busy", a_if.busy, 1'b1);
        a_if.blk_ready = 1'b1;
        fill(1'b0);
        drain();

        // 3: restart after two rows; the new block needs four fresh rows
        start_blk(1'b0, 4'd3);
        feed(2);
        start_blk(1'b1, 4'd9);
        feed(3);
        check_bit("t3_no_early", a_if.blk_valid, 1'b0);
        tick();
        feed(1);
        check_bit("t3_valid", a_if.blk_valid, 1'b1);
        check_vec("t3_tag", 132'(a_if.blk_tag), 132'(4'd9));

        // 4: commit and pop on the same edge with one block stored
        start_blk(1'b0, 4'd2);
        feed(3);
        a_if.blk_ready = 1'b1;
        feed(1);
        a_if.blk_ready = 1'b0;
        check_bit("t4_valid", a_if.blk_valid, 1'b1);
        check_vec("t4_tag", 132'(a_if.blk_tag), 132'(4'd2));
        tick();
        check_bit("t4_still", a_if.blk_valid, 1'b1);
        drain();

        // 5: reset with both slots full and a fill in progress
        start_blk(1'b1, 4'd4);
        fill(1'b0);
        start_blk(1'b0, 4'd5);
        fill(1'b0);
        start_blk(1'b1, 4'd6);
        feed(2);
        #3 RSTN = 1'b0;
        #1;
        check_bit("t5_valid", a_if.blk_valid, 1'b0);
        check_bit("t5_load_ready", a_if.load_ready, 1'b0);
        check_bit("t5_busy", a_if.busy, 1'b0);
        check_vec("t5_data", 132'(a_if.blk_data), 132'd0);
        check_vec("t5_tag", 132'(a_if.blk_tag), 132'd0);
        tick();
        RSTN = 1'b1;
        tick();
        a_if.blk_ready = 1'b1;
        start_blk(1'b0, 4'd7);
        fill(1'b0);
        drain();

        // 6: wide words, 16-bit rows, select the LS segment
        bexp = 128'd0;
        b_if.start = 1'b1; b_if.seg_sel = 3'd7; b_if.tag_in = 4'd6;
        tick();
        b_if.start = 1'b0;
        b_if.sram_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bw = {$urandom, $urandom, $urandom, $urandom};
            b_if.sram_data = bw;
            bexp = {bexp[111:0], bw[15:0]};
            tick();
        end
        b_if.sram_valid = 1'b0;
        check_bit("t6_valid", b_if.blk_valid, 1'b1);
        check_vec("t6_data", 132'(b_if.blk_data), 132'(bexp));
        check_vec("t6_tag", 132'(b_if.blk_tag), 132'(4'd6));
        check_bit("t6_busy", b_if.busy, 1'b0);
        b_if.blk_ready = 1'b1;
        tick();
        b_if.blk_ready = 1'b0;
        check_bit("t6_popped", b_if.blk_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
